alu_operand_sequencer: RTL and testbench

Upstream input stage for the 4-bit ALU top level. It synchronizes the board's slide switches, debounces two active-low pushbuttons, and walks a capture sequence (operand A, operand B, opcode) on successive ENTER presses. The result is one stable 10-bit operand/opcode word that drives the ALU top level's `switches` input. A valid flag and phase LEDs let the user see which field is armed.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/button_debouncer.sv | 53 +++++
 rtl/alu_operand_sequencer.sv | 82 ++++++++
 tb/tb_alu_operand_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and field layout for the ALU operand sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    CAP_A  = 2'd0,
    CAP_B  = 2'd1,
    CAP_OP = 2'd2,
    SHOW   = 2'd3
  } seq_state_t;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } alu_op_t;

  localparam int A_LSB   = 0;
  localparam int B_LSB   = 4;
  localparam int SEL_LSB = 6;
  localparam int A_W     = 4;
  localparam int B_W     = 2;
  localparam int SEL_W   = 2;
  localparam int WORD_W  = 10;

endpackage

// File: rtl/button_debouncer.sv
// Active-low pushbutton: 2-FF sync, stability counter, one-cycle pulse on accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int              CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the accepted one,
  // so it stops at CNT_MAX and can never wrap.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Captures A, B and opcode from the slide switches on successive ENTER presses
// and presents them as the ALU switches word.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] sw_in,
  input  logic              btn_enter_n,
  input  logic              btn_clear_n,
  output logic [WORD_W-1:0] alu_word,
  output logic              word_valid,
  output logic [1:0]        phase
);

  logic [WORD_W-1:0] sw_meta_q, sw_s_q;
  logic              enter_press, clear_press;
  seq_state_t        state_q, state_d;
  logic [A_W-1:0]    a_q, a_d;
  logic [B_W-1:0]    b_q, b_d;
  alu_op_t           sel_q, sel_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst_n(rst_n), .btn_n_i(btn_enter_n), .press_o(enter_press)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst_n(rst_n), .btn_n_i(btn_clear_n), .press_o(clear_press)
  );

  // CLEAR takes priority; fields otherwise hold until recaptured.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    if (clear_press) begin
      state_d = CAP_A;
      a_d     = '0;
      b_d     = '0;
      sel_d   = OP_MUL;
    end else if (enter_press) begin
      case (state_q)
        CAP_A:  begin a_d   = sw_s_q[A_W-1:0];             state_d = CAP_B;  end
        CAP_B:  begin b_d   = sw_s_q[B_W-1:0];             state_d = CAP_OP; end
        CAP_OP: begin sel_d = alu_op_t'(sw_s_q[SEL_W-1:0]); state_d = SHOW;   end
        default: state_d = CAP_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q <= '0;
      sw_s_q    <= '0;
      state_q   <= CAP_A;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= OP_MUL;
    end else begin
      sw_meta_q <= sw_in;
      sw_s_q    <= sw_meta_q;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    alu_word                      = '0;
    alu_word[A_LSB   +: A_W]      = a_q;
    alu_word[B_LSB   +: B_W]      = b_q;
    alu_word[SEL_LSB +: SEL_W]    = sel_q;
  end

  assign word_valid = (state_q == SHOW);
  assign phase      = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench: stimulus pushes expected outputs/press times, a monitor pops on each press.
module tb_alu_operand_sequencer;

  localparam int DC  = 4;
  localparam int LAT = 2 + DC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] sw_in = '0;
  logic       btn_enter_n = 1'b1;
  logic       btn_clear_n = 1'b1;
  logic [9:0] alu_word;
  logic       word_valid;
  logic [1:0] phase;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .sw_in(sw_in),
    .btn_enter_n(btn_enter_n), .btn_clear_n(btn_clear_n),
    .alu_word(alu_word), .word_valid(word_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  // Reference model: phase number and captured fields as plain integers.
  int m_ph = 0, m_a = 0, m_b = 0, m_sel = 0;

  typedef struct packed {
    logic [9:0] w;
    logic [1:0] ph;
    logic       v;
  } out_t;

  out_t exp_q[$];
  int   press_q[$];

  function automatic out_t model_out();
    out_t o;
    o.w  = 10'(m_sel * 64 + m_b * 16 + m_a);
    o.ph = 2'(m_ph);
    o.v  = (m_ph == 3);
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_ph = 0; m_a = 0; m_b = 0; m_sel = 0;
  endtask

  task automatic m_enter(input logic [9:0] sw);
    case (m_ph)
      0: begin m_a   = int'(sw) % 16; m_ph = 1; end
      1: begin m_b   = int'(sw) % 4;  m_ph = 2; end
      2: begin m_sel = int'(sw) % 4;  m_ph = 3; end
      default: m_ph = 0;
    endcase
  endtask

  task automatic chk_now(input string name);
    out_t e;
    e = model_out();
    chk({name, "_word"},  int'(alu_word),   int'(e.w));
    chk({name, "_phase"}, int'(phase),      int'(e.ph));
    chk({name, "_valid"}, int'(word_valid), int'(e.v));
  endtask

  // Clean press of ENTER and/or CLEAR, held 10 cycles, then released and settled.
  task automatic press(input bit ent, input bit clr, input logic [9:0] sw);
    @(negedge clk);
    sw_in = sw;
    repeat (3) @(negedge clk);
    if (ent) press_q.push_back(cyc);
    if (clr) m_clear();
    else     m_enter(sw);
    exp_q.push_back(model_out());
    btn_enter_n = ~ent;
    btn_clear_n = ~clr;
    repeat (10) @(negedge clk);
    btn_enter_n = 1'b1;
    btn_clear_n = 1'b1;
    repeat (14) @(negedge clk);
  endtask

  task automatic glitch(input int low_cycles);
    @(negedge clk);
    btn_enter_n = 1'b0;
    repeat (low_cycles) @(negedge clk);
    btn_enter_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Monitor: every ENTER pulse is checked for latency and width; every cycle
  // after any pulse the outputs are compared against the next expected value,
  // and in all other cycles the outputs must not move.
  logic [12:0] prev_out = '0;
  logic        pe_prev = 1'b0, pany_prev = 1'b0;

  always @(negedge clk) begin
    logic [12:0] cur;
    out_t        e;
    int          t;
    cur = {alu_word, phase, word_valid};
    if (!rst_n) begin
      pe_prev   = 1'b0;
      pany_prev = 1'b0;
    end else begin
      if (dut.enter_press) begin
        chk("press_width", int'(pe_prev), 0);
        if (press_q.size() == 0) begin
          chk("unexpected_press", 1, 0);
        end else begin
          t = press_q.pop_front();
          chk("press_latency", cyc - t, LAT);
        end
      end
      if (pany_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_update", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word",  int'(alu_word),   int'(e.w));
          chk("sb_phase", int'(phase),      int'(e.ph));
          chk("sb_valid", int'(word_valid), int'(e.v));
        end
      end else begin
        chk("hold_outputs", int'(cur), int'(prev_out));
      end
      pe_prev   = dut.enter_press;
      pany_prev = dut.enter_press | dut.clear_press;
    end
    prev_out = cur;
  end

  initial begin
    // Reset with random inputs
    rst_n       = 1'b0;
    sw_in       = 10'($urandom);
    btn_enter_n = 1'($urandom);
    btn_clear_n = 1'($urandom);
    repeat (5) @(negedge clk);
    chk_now("reset");
    btn_enter_n = 1'b1;
    btn_clear_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk_now("post_reset_idle");

    // Full sequence -> 0x015
    press(1, 0, 10'h005);
    press(1, 0, 10'h001);
    press(1, 0, 10'h000);
    chk("seq_word", int'(alu_word), 'h015);
    chk_now("seq");

    // Bounce rejection from CAP_A
    press(0, 1, 10'h000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); btn_enter_n = 1'b0;
      @(negedge clk);
      @(negedge clk); btn_enter_n = 1'b1;
    end
    repeat (12) @(negedge clk);
    chk_now("bounce_rejected");
    press(1, 0, 10'h009);
    chk_now("after_bounce");

    // CLEAR mid-sequence
    press(0, 1, 10'h000);
    press(1, 0, 10'h00F);
    press(1, 0, 10'h003);
    chk("mid_phase", int'(phase), 2);
    press(0, 1, 10'h000);
    chk_now("clear_mid");

    // Simultaneous ENTER+CLEAR in CAP_B
    press(1, 0, 10'h006);
    press(1, 1, 10'h003);
    chk("simul_phase", int'(phase), 0);
    chk("simul_b", int'(alu_word[5:4]), 0);

    // Hold in SHOW
    press(1, 0, 10'h00F);
    press(1, 0, 10'h003);
    press(1, 0, 10'h003);
    chk("show_word", int'(alu_word), 'h0FF);
    @(negedge clk); sw_in = 10'h3AA;
    repeat (10) @(negedge clk);
    chk("show_hold", int'(alu_word), 'h0FF);
    press(1, 0, 10'h3AA);
    chk_now("leave_show");
    press(1, 0, 10'h3AA);
    chk("recapture_a", int'(alu_word), 'h0FA);

    // Randomized presses and short glitches
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if      (r == 0) press(0, 1, 10'($urandom));
      else if (r == 1) press(1, 1, 10'($urandom));
      else if (r == 2) glitch($urandom_range(1, DC));
      else             press(1, 0, 10'($urandom));
    end
    chk_now("random_end");

    // Reset mid-operation with ENTER held through release
    press(1, 0, 10'h00C);
    @(negedge clk);
    btn_enter_n = 1'b0;
    rst_n = 1'b0;
    #1;
    m_clear();
    chk_now("async_reset");
    repeat (4) @(negedge clk);
    sw_in = 10'h007;
    rst_n = 1'b1;
    press_q.push_back(cyc);
    m_enter(10'h007);
    exp_q.push_back(model_out());
    repeat (10) @(negedge clk);
    btn_enter_n = 1'b1;
    repeat (14) @(negedge clk);
    chk_now("held_through_reset");

    chk("pending_outputs", exp_q.size(), 0);
    chk("pending_presses", press_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
